// File: rtl/ysyx_25040105_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040105_sram_pkg
// Description : Shared FSM encodings, error codes and byte-merge helper for
//               the latency-configurable SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040105_sram_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic c_err_none   = 1'b0;
    localparam logic c_err_access = 1'b1;

    // Replace only the strobed byte lanes of a word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25040105_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040105_sram_array
// Description : Word storage with synchronous byte-strobed write and
//               combinational read on a shared index.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040105_sram_array
    import ysyx_25040105_sram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata
);

    // Contents are deliberately never reset.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
        end
    end

    assign rdata = mem[idx];

endmodule
`default_nettype wire

// File: rtl/ysyx_25040105_sram.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040105_sram
// Description : Single-outstanding valid/ready SRAM responder with a fixed
//               programmable response latency and range/alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040105_sram
    import ysyx_25040105_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_span     = 33'(DEPTH_WORDS * 4);
    localparam logic [3:0]  c_lat_load = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic        wen_q,   wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic             enter_resp;
    logic [31:0]      acc_addr;
    logic             acc_wen;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic [31:0]      acc_off;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    // With LATENCY==1 the access resolves on the acceptance edge itself, so
    // it must be taken straight from the request inputs.
    always_comb begin
        if (state_q == c_st_idle) begin
            acc_addr  = req_addr;
            acc_wen   = req_wen;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_addr  = addr_q;
            acc_wen   = wen_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
    end

    assign acc_off = acc_addr - ADDR_BASE;
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < ADDR_BASE)
                   || ({1'b0, acc_off} >= c_span);
    assign acc_idx = acc_off[IDX_W+1:2];

    // The counter holds the cycles still to wait; RESP is entered on the edge
    // that takes it to zero, so resp_valid shows up in the LATENCY-th cycle
    // counted from the acceptance cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (LATENCY == 1) begin
                        state_d    = c_st_resp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = c_st_wait;
                        cnt_d   = c_lat_load;
                    end
                end
            end
            c_st_wait: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = c_st_resp;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_st_resp: begin
                if (resp_ready) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
        if (enter_resp) begin
            err_d   = acc_err ? c_err_access : c_err_none;
            rdata_d = (acc_err || acc_wen) ? 32'd0 : mem_rdata;
        end
    end

    // Reset on the commit edge suppresses the write as well as the response.
    assign mem_we = enter_resp && acc_wen && !acc_err && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_st_idle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wen_q   <= 1'b0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    ysyx_25040105_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .wstrb (acc_wstrb),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state_q == c_st_idle);
    assign resp_valid = (state_q == c_st_resp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire
